display_scheduler: RTL and testbench



---
 rtl/display_pkg.sv | 44 ++++
 rtl/bin2bcd_seq.sv | 64 ++++++
 rtl/display_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_display_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: display FSM state encoding, glyph selection, active-low segment
// constants and the BCD digit to 7-segment decoder (bit order {g,f,e,d,c,b,a}).
package display_pkg;

  typedef enum logic [2:0] {
    ST_WAIT  = 3'd0,
    ST_LIVE  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_STALE = 3'd3,
    ST_ERR   = 3'd4
  } disp_state_t;

  // What the shown digits represent; latched together with the digits at frame wrap
  typedef enum logic [1:0] {
    GLYPH_DASH   = 2'd0,
    GLYPH_ERR    = 2'd1,
    GLYPH_DIGITS = 2'd2
  } glyph_t;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'h3F;
  localparam logic [6:0] SEG_E      = 7'h06;
  localparam logic [6:0] SEG_R      = 7'h2F;
  localparam logic [7:0] MAX_INCHES = 8'd99;

  function automatic logic [6:0] seven_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'h40;
      4'd1:    pattern = 7'h79;
      4'd2:    pattern = 7'h24;
      4'd3:    pattern = 7'h30;
      4'd4:    pattern = 7'h19;
      4'd5:    pattern = 7'h12;
      4'd6:    pattern = 7'h02;
      4'd7:    pattern = 7'h78;
      4'd8:    pattern = 7'h00;
      4'd9:    pattern = 7'h10;
      default: pattern = SEG_OFF;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to two-digit BCD converter.
// start is taken only while idle; 8 shift cycles follow and done pulses on the 9th.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] bcd_q;
  logic [7:0] bin_q;
  logic [2:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] bcd_adj;

  // Only two BCD digits are kept: callers saturate the input to 99 beforehand
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 2; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (!busy_q) begin
      done_q <= 1'b0;
      if (start) begin
        bcd_q  <= '0;
        bin_q  <= bin;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end
    end else if (done_q) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bcd_q <= {bcd_adj[6:0], bin_q[7]};
      bin_q <= {bin_q[6:0], 1'b0};
      cnt_q <= cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        done_q <= 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: mode FSM, BCD conversion scheduling and tear-free 2-digit scan.
// Optional PEAK_HOLD_EN adds peak_clr and shows the peak sample while in HOLD.
module display_scheduler
  import display_pkg::*;
#(
  parameter int SCAN_W      = 16,
  parameter int BLANK_CYC   = 64,
  parameter int TIMEOUT_W   = 24,
  parameter int TIMEOUT_CYC = 6000000
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef PEAK_HOLD_EN
  input  logic       peak_clr,
`endif
  input  logic [7:0] meas_inches,
  input  logic       meas_valid,
  input  logic       meas_error,
  input  logic       hold_btn,
  output logic [6:0] seg,
  output logic       dig0,
  output logic       dig1,
  output logic [2:0] disp_state
);

  localparam logic [SCAN_W-2:0]    BLANK_V   = (SCAN_W-1)'(BLANK_CYC);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT_CYC);

  disp_state_t          state_q, state_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d, timer_inc;
  logic [SCAN_W-1:0]    scan_q;
  logic                 frame_wrap;
  logic                 accept;
  logic [7:0]           sat;
  logic                 req_valid;
  logic [7:0]           req_value;
  logic                 buf_valid_q;
  logic [7:0]           buf_value_q;
  logic                 conv_start, conv_busy, conv_done;
  logic [7:0]           conv_bin;
  logic [3:0]           conv_tens, conv_ones;
  logic [3:0]           pend_tens_q, pend_ones_q;
  logic [3:0]           shown_tens_q, shown_ones_q;
  glyph_t               glyph_sel, shown_glyph_q;
  logic                 in_blank;
  logic [6:0]           seg_d;
  logic                 dig0_d, dig1_d;

  assign sat        = (meas_inches > MAX_INCHES) ? MAX_INCHES : meas_inches;
  assign timer_inc  = timer_q + TIMEOUT_W'(1);
  assign frame_wrap = &scan_q;

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    accept  = meas_valid && !meas_error && (state_q != ST_HOLD);
    if (meas_error) begin
      state_d = ST_ERR;
    end else begin
      case (state_q)
        ST_WAIT, ST_STALE, ST_ERR: begin
          if (meas_valid) state_d = ST_LIVE;
        end
        ST_LIVE: begin
          if (hold_btn) state_d = ST_HOLD;
          else if (!meas_valid && timer_inc == TIMEOUT_V) state_d = ST_STALE;
        end
        ST_HOLD: begin
          if (hold_btn) state_d = ST_LIVE;
        end
        default: state_d = ST_WAIT;
      endcase
    end
    case (state_q)
      ST_LIVE: timer_d = accept ? '0 : timer_inc;
      ST_HOLD: timer_d = hold_btn ? '0 : timer_q;
      default: timer_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

`ifdef PEAK_HOLD_EN
  logic [7:0] peak_q, peak_d;
  logic       hold_entry;

  always_comb begin
    peak_d = peak_q;
    if (peak_clr) begin
      peak_d = '0;
    end else if (accept && (sat > peak_q)) begin
      peak_d = sat;
    end
  end

  // Entering HOLD replaces any same-cycle sample conversion with the peak
  assign hold_entry = (state_q == ST_LIVE) && (state_d == ST_HOLD);
  assign req_valid  = accept || hold_entry;
  assign req_value  = hold_entry ? peak_d : sat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end
`else
  assign req_valid = accept;
  assign req_value = sat;
`endif

  // A request arriving while busy parks in the one-entry buffer, newest wins
  assign conv_start = (req_valid || buf_valid_q) && !conv_busy;
  assign conv_bin   = req_valid ? req_value : buf_value_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_value_q <= '0;
    end else if (req_valid && conv_busy) begin
      buf_valid_q <= 1'b1;
      buf_value_q <= req_value;
    end else if (!conv_busy) begin
      buf_valid_q <= 1'b0;
    end
  end

  bin2bcd_seq u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (conv_bin),
    .busy    (conv_busy),
    .done    (conv_done),
    .tens    (conv_tens),
    .ones    (conv_ones)
  );

  always_comb begin
    case (state_q)
      ST_WAIT, ST_STALE: glyph_sel = GLYPH_DASH;
      ST_ERR:            glyph_sel = GLYPH_ERR;
      default:           glyph_sel = GLYPH_DIGITS;
    endcase
  end

  // Shown digits and glyph only move on the wrap edge, inside the blank window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_q        <= '0;
      pend_tens_q   <= '0;
      pend_ones_q   <= '0;
      shown_tens_q  <= '0;
      shown_ones_q  <= '0;
      shown_glyph_q <= GLYPH_DASH;
    end else begin
      scan_q <= scan_q + SCAN_W'(1);
      if (conv_done) begin
        pend_tens_q <= conv_tens;
        pend_ones_q <= conv_ones;
      end
      if (frame_wrap) begin
        shown_tens_q  <= pend_tens_q;
        shown_ones_q  <= pend_ones_q;
        shown_glyph_q <= glyph_sel;
      end
    end
  end

  assign in_blank = scan_q[SCAN_W-2:0] < BLANK_V;

  always_comb begin
    seg_d  = SEG_OFF;
    dig0_d = 1'b0;
    dig1_d = 1'b0;
    if (!in_blank) begin
      if (scan_q[SCAN_W-1]) begin
        dig0_d = 1'b1;
        case (shown_glyph_q)
          GLYPH_DASH: seg_d = SEG_DASH;
          GLYPH_ERR:  seg_d = SEG_R;
          default:    seg_d = seven_seg(shown_ones_q);
        endcase
      end else begin
        dig1_d = 1'b1;
        case (shown_glyph_q)
          GLYPH_DASH: seg_d = SEG_DASH;
          GLYPH_ERR:  seg_d = SEG_E;
          default:    seg_d = (shown_tens_q == 4'd0) ? SEG_OFF : seven_seg(shown_tens_q);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg  <= SEG_OFF;
      dig0 <= 1'b0;
      dig1 <= 1'b0;
    end else begin
      seg  <= seg_d;
      dig0 <= dig0_d;
      dig1 <= dig1_d;
    end
  end

  assign disp_state = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed self-checking bench for display_scheduler with a
// 256-cycle frame; the peak-hold sequence is built only when PEAK_HOLD_EN is defined.
module tb_display_scheduler;

  localparam int SCAN_W      = 8;
  localparam int FRAME       = 1 << SCAN_W;
  localparam int BLANK_CYC   = 64;
  localparam int TIMEOUT_W   = 12;
  localparam int TIMEOUT_CYC = 1000;

  localparam logic [6:0] P_OFF  = 7'h7F;
  localparam logic [6:0] P_DASH = 7'h3F;
  localparam logic [6:0] P_E    = 7'h06;
  localparam logic [6:0] P_R    = 7'h2F;
  localparam logic [6:0] P_0    = 7'h40;
  localparam logic [6:0] P_1    = 7'h79;
  localparam logic [6:0] P_2    = 7'h24;
  localparam logic [6:0] P_3    = 7'h30;
  localparam logic [6:0] P_4    = 7'h19;
  localparam logic [6:0] P_5    = 7'h12;
  localparam logic [6:0] P_6    = 7'h02;
  localparam logic [6:0] P_7    = 7'h78;
  localparam logic [6:0] P_9    = 7'h10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] meas_inches = '0;
  logic       meas_valid = 1'b0;
  logic       meas_error = 1'b0;
  logic       hold_btn = 1'b0;
`ifdef PEAK_HOLD_EN
  logic       peak_clr = 1'b0;
`endif
  logic [6:0] seg;
  logic       dig0, dig1;
  logic [2:0] disp_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int n     = 0;

  display_scheduler #(
    .SCAN_W      (SCAN_W),
    .BLANK_CYC   (BLANK_CYC),
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
`ifdef PEAK_HOLD_EN
    .peak_clr    (peak_clr),
`endif
    .meas_inches (meas_inches),
    .meas_valid  (meas_valid),
    .meas_error  (meas_error),
    .hold_btn    (hold_btn),
    .seg         (seg),
    .dig0        (dig0),
    .dig1        (dig1),
    .disp_state  (disp_state)
  );

  always #5 clk = ~clk;

  // Mirrors the scan counter: clock edges seen since reset was released
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic e, input logic h, input logic [7:0] value);
    meas_inches = value;
    meas_valid  = v;
    meas_error  = e;
    hold_btn    = h;
    tick();
    meas_valid  = 1'b0;
    meas_error  = 1'b0;
    hold_btn    = 1'b0;
  endtask

  // Advance at least one cycle until the DUT scan counter equals s;
  // outputs then reflect counter value s-1
  task automatic goto_scan(input int s);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (((cyc % FRAME) != s) && (k < 2 * FRAME));
    if ((cyc % FRAME) != s) checkOutput("goto_scan_timeout", cyc % FRAME, s);
  endtask

  task automatic check_frame(input string tag, input logic [6:0] tens, input logic [6:0] ones);
    goto_scan(0);
    goto_scan(101);
    checkOutput({tag, "_tens"}, {dig1, dig0, seg}, {1'b1, 1'b0, tens});
    goto_scan(201);
    checkOutput({tag, "_ones"}, {dig1, dig0, seg}, {1'b0, 1'b1, ones});
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] reset and idle frames");
    repeat (3) tick();
    checkOutput("rst_state", disp_state, 3'd0);
    checkOutput("rst_out", {dig1, dig0, seg}, {2'b00, P_OFF});
    reset_n = 1'b1;
    goto_scan(0);
    goto_scan(0);
    goto_scan(11);
    checkOutput("blank_tens_early", {dig1, dig0, seg}, {2'b00, P_OFF});
    goto_scan(64);
    checkOutput("blank_tens_last", {dig1, dig0, seg}, {2'b00, P_OFF});
    goto_scan(65);
    checkOutput("wait_tens_first", {dig1, dig0, seg}, {2'b10, P_DASH});
    goto_scan(192);
    checkOutput("blank_ones_last", {dig1, dig0, seg}, {2'b00, P_OFF});
    goto_scan(193);
    checkOutput("wait_ones_first", {dig1, dig0, seg}, {2'b01, P_DASH});
    checkOutput("wait_state", disp_state, 3'd0);

    $display("[TB] sample 72 and conversion latency");
    goto_scan(100);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd72);
    n = 0;
    while (!dut.u_bcd.done && n < 20) begin
      tick();
      n++;
    end
    checkOutput("bcd_latency", n, 8);
    tick();
    checkOutput("bcd_done_pulse", dut.u_bcd.done, 1'b0);
    checkOutput("live_state", disp_state, 3'd1);
    goto_scan(201);
    checkOutput("no_tear_ones", {dig1, dig0, seg}, {2'b01, P_DASH});
    check_frame("live72", P_7, P_2);

    $display("[TB] back-to-back 5 then 150");
    goto_scan(240);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd5);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd150);
    check_frame("lz05", P_OFF, P_5);
    check_frame("sat99", P_9, P_9);

    $display("[TB] hold toggling");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("hold_state", disp_state, 3'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd30);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd40);
    check_frame("hold99", P_9, P_9);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("unhold_state", disp_state, 3'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd40);
    check_frame("live40", P_4, P_0);

    applyStimulus(1'b1, 1'b0, 1'b1, 8'd30);
    checkOutput("hold_same_cycle_state", disp_state, 3'd2);
`ifdef PEAK_HOLD_EN
    check_frame("hold_same_cycle", P_9, P_9);
`else
    check_frame("hold_same_cycle", P_3, P_0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);

    $display("[TB] error, recovery and timeout");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd55);
    checkOutput("err_state", disp_state, 3'd4);
    check_frame("err", P_E, P_R);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("err_hold_ignored", disp_state, 3'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd55);
    t0 = cyc;
    checkOutput("recover_state", disp_state, 3'd1);
    check_frame("live55", P_5, P_5);
    while (cyc < t0 + TIMEOUT_CYC - 1) tick();
    checkOutput("timeout_minus1", disp_state, 3'd1);
    tick();
    checkOutput("timeout_stale", disp_state, 3'd3);
    check_frame("stale", P_DASH, P_DASH);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    checkOutput("stale_hold_ignored", disp_state, 3'd3);

    $display("[TB] reset during conversion");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd88);
    repeat (3) tick();
    checkOutput("busy_before_rst", dut.u_bcd.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("busy_after_rst", dut.u_bcd.busy, 1'b0);
    checkOutput("state_after_rst", disp_state, 3'd0);
    checkOutput("out_after_rst", {dig1, dig0, seg}, {2'b00, P_OFF});
    repeat (2) tick();
    reset_n = 1'b1;
    check_frame("post_rst", P_DASH, P_DASH);

`ifdef PEAK_HOLD_EN
    $display("[TB] peak hold");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd20);
    repeat (12) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd61);
    repeat (12) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd33);
    repeat (12) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    check_frame("peak61", P_6, P_1);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd12);
    repeat (12) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
    check_frame("peak12", P_1, P_2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
